ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: all sequential state SHALL clear immediately when rst rises, regardless of clk.
REQ-002 The ports SHALL be, listed as name, direction, width, meaning (clock and reset first):
- clk  in  1: rising-edge clock.
- rst  in  1: asynchronous active-high reset.
- stall  in  1: hold the EX/MEM register.
- flush  in  1: load a bubble into the EX/MEM register.
- id_ex_wb  in  2: {regwrite, memtoreg}.
- id_ex_mem  in  3: {branch, memread, memwrite}.
- id_ex_execute  in  4: {regdst, aluop[1:0], alusrc}.
- id_ex_npc  in  32: PC+4 of the instruction.
- id_ex_readdat1  in  32: rs value.
- id_ex_readdat2  in  32: rt value.
- id_ex_sign_ext  in  32: sign-extended immediate; bits [5:0] are funct.
- id_ex_instr_bits_25_21  in  5: rs number (forwarding).
- id_ex_instr_bits_20_16  in  5: rt number.
- id_ex_instr_bits_15_11  in  5: rd number.
- wb_reg_write  in  1: MEM/WB write enable.
- wb_write_reg_location  in  5: MEM/WB destination register.
- mem_wb_write_data  in  32: MEM/WB write data.
- ex_mem_wb  out  2: registered WB controls.
- ex_mem_m  out  3: registered MEM controls.
- ex_mem_branch_target  out  32: registered branch target.
- ex_mem_zero  out  1: registered ALU zero flag.
- ex_mem_alu_result  out  32: registered ALU result.
- ex_mem_write_data  out  32: registered store data (operand B before the alusrc mux).
- ex_mem_write_reg  out  5: registered destination register.

Function
REQ-003 The ALU control SHALL decode aluop as follows: 00 -> add; 01 -> sub; 10 -> funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); any other funct, or aluop 11 -> result 32'h0.
REQ-004 Operand B SHALL be id_ex_sign_ext when alusrc=1, else the (forwarded) rt value.
REQ-005 add and sub SHALL be 32-bit modulo with no overflow flag; slt SHALL be a signed compare producing 32'h1 or 32'h0.
REQ-006 The zero flag SHALL be 1 exactly when the 32-bit ALU result is 0.
REQ-007 The branch target SHALL be id_ex_npc + (id_ex_sign_ext << 2), modulo 2^32.
REQ-008 The destination register SHALL be rd when regdst=1, else rt.
REQ-009 All outputs SHALL be registered with one-cycle latency: ID/EX values present before edge N appear on the outputs after edge N.
REQ-010 stall=1 SHALL hold every output register unchanged.
REQ-011 flush=1 SHALL load zeros into all output registers (a bubble with no writes and no memory access).
REQ-012 flush SHALL take priority over stall when both are asserted in the same cycle.

Reset
REQ-013 Reset SHALL drive every output to 0: ex_mem_wb=2'b00, ex_mem_m=3'b000, all 32-bit fields 32'h0, ex_mem_zero=0, ex_mem_write_reg=5'd0.
REQ-014 A reset asserted mid-stall or mid-flush SHALL override both; the first edge after reset release SHALL capture normally.

Configuration
REQ-015 Macro EX_FORWARD_EN SHALL compile in the forwarding unit, which selects each of operands A and B as:
- the current ex_mem_alu_result when ex_mem_wb[1]=1, ex_mem_write_reg!=0 and it matches the operand's source register;
- else mem_wb_write_data when wb_reg_write=1, wb_write_reg_location!=0 and it matches;
- else the ID/EX value.
The EX/MEM match SHALL win over the MEM/WB match.
REQ-016 Without EX_FORWARD_EN, operands SHALL be id_ex_readdat1 and id_ex_readdat2 unmodified, and the forwarding inputs SHALL be ignored; the ports SHALL remain present.

Structure
REQ-017 A shared package SHALL hold the control-bit index constants, the aluop encodings, the ALU operation codes (add 0010, sub 0110, and 0000, or 0001, slt 0111) and the funct codes.
REQ-018 The ALU with its ALU-control decode SHALL be a separate sub-module named alu; the operand muxes, forwarding and the EX/MEM register SHALL reside in ex_stage.

Verification
REQ-019 The bench SHALL cover at least these directed scenarios:
- R-type add: readdat1=5, readdat2=7, aluop=10, funct=100000, regdst=1, rd=3 -> next cycle alu_result=12, write_reg=3, zero=0.
- beq path: aluop=01, operands 9/9, npc=32'h100, sign_ext=4 -> zero=1, branch_target=32'h110.
- slt signed: A=32'hFFFFFFFF, B=1 -> alu_result=1.
- Stall then flush: stall=1 holds prior values over 3 cycles; stall=1 with flush=1 -> all outputs 0.
- Forwarding (EX_FORWARD_EN): previous instruction writes r4=20, current reads rs=4 with stale readdat1=0, addi imm 1 -> alu_result=21; same scenario without the macro -> alu_result=1.
- Async reset mid-operation: rst asserted between edges -> outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared control-bit indices, aluop/funct encodings and ALU operation codes
// for the EX stage and its ALU.
package ex_stage_pkg;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } alu_op_e;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  function automatic alu_op_e funct_to_op(input logic [5:0] fn);
    return fn == FN_ADD ? ALU_ADD :
           fn == FN_SUB ? ALU_SUB :
           fn == FN_AND ? ALU_AND :
           fn == FN_OR  ? ALU_OR  :
           fn == FN_SLT ? ALU_SLT : ALU_NOP;
  endfunction
endpackage

// File: rtl/ex_stage_alu.sv
// alu: ALU-control decode of aluop/funct plus the 32-bit ALU; unknown operations yield 0.
module alu
  import ex_stage_pkg::*;
(
  input  logic [1:0]  i_aluop,
  input  logic [5:0]  i_funct,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_zero
);
  alu_op_e w_op;
  always_comb begin
    w_op = i_aluop == ALUOP_ADD   ? ALU_ADD :
           i_aluop == ALUOP_SUB   ? ALU_SUB :
           i_aluop == ALUOP_FUNCT ? funct_to_op(i_funct) : ALU_NOP;
    o_result = w_op == ALU_ADD ? i_a + i_b :
               w_op == ALU_SUB ? i_a - i_b :
               w_op == ALU_AND ? i_a & i_b :
               w_op == ALU_OR  ? i_a | i_b :
               w_op == ALU_SLT ? {31'd0, $signed(i_a) < $signed(i_b)} : 32'd0;
    o_zero = o_result == 32'd0;
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand muxes, optional forwarding (EX_FORWARD_EN) and the EX/MEM pipeline register.
// Without EX_FORWARD_EN the forwarding inputs are present but ignored.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  id_ex_wb,
  input  logic [2:0]  id_ex_mem,
  input  logic [3:0]  id_ex_execute,
  input  logic [31:0] id_ex_npc,
  input  logic [31:0] id_ex_readdat1,
  input  logic [31:0] id_ex_readdat2,
  input  logic [31:0] id_ex_sign_ext,
  input  logic [4:0]  id_ex_instr_bits_25_21,
  input  logic [4:0]  id_ex_instr_bits_20_16,
  input  logic [4:0]  id_ex_instr_bits_15_11,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg_location,
  input  logic [31:0] mem_wb_write_data,
  output logic [1:0]  ex_mem_wb,
  output logic [2:0]  ex_mem_m,
  output logic [31:0] ex_mem_branch_target,
  output logic        ex_mem_zero,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_write_data,
  output logic [4:0]  ex_mem_write_reg
);
  logic [1:0]  r_wb;
  logic [2:0]  r_m;
  logic [31:0] r_bt;
  logic        r_zero;
  logic [31:0] r_res;
  logic [31:0] r_wd;
  logic [4:0]  r_wr;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_opb;
  logic [31:0] w_res;
  logic        w_zero;
`ifdef EX_FORWARD_EN
  logic w_ex_a, w_ex_b, w_wb_a, w_wb_b;
  always_comb begin
    w_ex_a = r_wb[WB_REGWRITE] && r_wr != 5'd0 && r_wr == id_ex_instr_bits_25_21;
    w_ex_b = r_wb[WB_REGWRITE] && r_wr != 5'd0 && r_wr == id_ex_instr_bits_20_16;
    w_wb_a = wb_reg_write && wb_write_reg_location != 5'd0 && wb_write_reg_location == id_ex_instr_bits_25_21;
    w_wb_b = wb_reg_write && wb_write_reg_location != 5'd0 && wb_write_reg_location == id_ex_instr_bits_20_16;
    w_a = w_ex_a ? r_res : w_wb_a ? mem_wb_write_data : id_ex_readdat1;
    w_b = w_ex_b ? r_res : w_wb_b ? mem_wb_write_data : id_ex_readdat2;
  end
`else
  logic w_unused;
  assign w_unused = ^{wb_reg_write, wb_write_reg_location, mem_wb_write_data, id_ex_instr_bits_25_21};
  assign w_a = id_ex_readdat1;
  assign w_b = id_ex_readdat2;
`endif
  assign w_opb = id_ex_execute[EX_ALUSRC] ? id_ex_sign_ext : w_b;
  alu u_alu (
    .i_aluop  (id_ex_execute[EX_ALUOP_HI:EX_ALUOP_LO]),
    .i_funct  (id_ex_sign_ext[5:0]),
    .i_a      (w_a),
    .i_b      (w_opb),
    .o_result (w_res),
    .o_zero   (w_zero)
  );
  // flush wins over stall so a squashed instruction cannot linger in a held register
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      r_wb   <= '0;
      r_m    <= '0;
      r_bt   <= '0;
      r_zero <= 1'b0;
      r_res  <= '0;
      r_wd   <= '0;
      r_wr   <= '0;
    end else if (!stall) begin
      r_wb   <= {id_ex_wb[WB_REGWRITE], id_ex_wb[WB_MEMTOREG]};
      r_m    <= {id_ex_mem[M_BRANCH], id_ex_mem[M_MEMREAD], id_ex_mem[M_MEMWRITE]};
      r_bt   <= id_ex_npc + {id_ex_sign_ext[29:0], 2'b00};
      r_zero <= w_zero;
      r_res  <= w_res;
      r_wd   <= w_b;
      r_wr   <= id_ex_execute[EX_REGDST] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
    end
  end
  assign ex_mem_wb            = r_wb;
  assign ex_mem_m             = r_m;
  assign ex_mem_branch_target = r_bt;
  assign ex_mem_zero          = r_zero;
  assign ex_mem_alu_result    = r_res;
  assign ex_mem_write_data    = r_wd;
  assign ex_mem_write_reg     = r_wr;
endmodule
